// File: rtl/chip8_mem_arbiter_if.sv
// Request/response bus between CHIP-8 clients and the shared-memory arbiter.
// All per-port fields are packed flat, port p occupying slice p of each vector.
//
// Handshake: a port asserts req_valid_in with a stable payload and keeps both
// until the cycle in which req_ready_out is also high for that port. That
// cycle is the transfer. req_ready_out may depend combinationally on
// req_valid_in. Completion is a single-cycle rsp_valid_out pulse with no
// back-pressure.
interface chip8_mem_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int WIDTH      = 8,
    parameter int MAX_BYTES  = 2
);
    localparam int SZW = $clog2(MAX_BYTES);

    logic [NUM_PORTS-1:0]                 req_valid_in;
    logic [NUM_PORTS-1:0]                 req_ready_out;
    logic [NUM_PORTS-1:0]                 req_we_in;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]      req_addr_in;
    logic [NUM_PORTS*SZW-1:0]             req_size_in;
    logic [NUM_PORTS*MAX_BYTES*WIDTH-1:0] req_data_in;
    logic [NUM_PORTS-1:0]                 rsp_valid_out;
    logic [MAX_BYTES*WIDTH-1:0]           rsp_data_out;

    // Arbiter side: accepts requests, produces responses.
    modport slave (
        input  req_valid_in,
        input  req_we_in,
        input  req_addr_in,
        input  req_size_in,
        input  req_data_in,
        output req_ready_out,
        output rsp_valid_out,
        output rsp_data_out
    );

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid_in,
        output req_we_in,
        output req_addr_in,
        output req_size_in,
        output req_data_in,
        input  req_ready_out,
        input  rsp_valid_out,
        input  rsp_data_out
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Round-robin arbiter serialising multi-byte CHIP-8 client accesses onto one
// byte-wide synchronous BRAM port. Multi-byte requests are issued big-endian
// (lowest address carries the most significant used byte); read bytes are
// reassembled and returned right-justified in a one-cycle response.
module chip8_mem_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_WIDTH   = 13,
    parameter int WIDTH        = 8,
    parameter int MAX_BYTES    = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    chip8_mem_arbiter_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_we_out,
    output logic [WIDTH-1:0]      mem_din_out,
    input  logic [WIDTH-1:0]      mem_dout_in,
    output logic                  busy_out,
    output logic [1:0]            state_dbg_out
);
    localparam int SZW = $clog2(MAX_BYTES);
    localparam int PW  = $clog2(NUM_PORTS);
    localparam int DW  = MAX_BYTES * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Grant path
    logic [PW-1:0]        last_grant_q;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        cand;
    logic                 gnt_found;
    logic [NUM_PORTS-1:0] gnt_onehot;
    logic                 accept;

    // Payload of the granted port
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [SZW-1:0]        sel_size;
    logic [SZW-1:0]        sel_size_cl;
    logic [DW-1:0]         sel_data;
    logic [DW-1:0]         sel_aligned;

    // Latched transaction
    logic                  we_q;
    logic [SZW-1:0]        size_q;
    logic [PW-1:0]         port_q;
    logic [DW-1:0]         wdata_q;
    logic [SZW-1:0]        issue_cnt_q;
    logic [SZW-1:0]        cap_cnt_q;
    logic [READ_LATENCY-1:0] rd_pipe_q;
    logic [DW-1:0]         asm_q;
    logic [DW-1:0]         asm_next;
    logic [DW-1:0]         rsp_data_q;
    logic [NUM_PORTS-1:0]  rsp_valid;

    // Memory port registers
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [WIDTH-1:0]      mem_din_q;

    logic issue_last;
    logic capture;
    logic capture_last;

    // Round-robin search: first valid port after the last one granted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!gnt_found && bus.req_valid_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Ready is offered only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_onehot = '0;
        accept     = 1'b0;
        if (!rst_in && state_q == S_IDLE && gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
            accept              = 1'b1;
        end
    end

    // Select the granted port's payload, clamp its size, left-align its data
    // so the first byte to issue sits in the top byte lane.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_size = '0;
        sel_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_idx == PW'(p)) begin
                sel_we   = bus.req_we_in[p];
                sel_addr = bus.req_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_size = bus.req_size_in[p*SZW +: SZW];
                sel_data = bus.req_data_in[p*DW +: DW];
            end
        end
        sel_size_cl = (int'(sel_size) > MAX_BYTES - 1) ? SZW'(MAX_BYTES - 1) : sel_size;
        sel_aligned = sel_data << ((MAX_BYTES - 1 - int'(sel_size_cl)) * WIDTH);
    end

    assign issue_last   = (issue_cnt_q == size_q);
    assign capture      = rd_pipe_q[READ_LATENCY-1];
    assign capture_last = capture && (cap_cnt_q == size_q);
    assign asm_next     = (asm_q << WIDTH) | DW'(mem_dout_in);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        rsp_valid = '0;
        busy_out  = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: if (issue_last) state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (capture_last) state_d = S_RESP;
            S_RESP: begin
                rsp_valid[port_q] = 1'b1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction datapath: latch on accept, step bytes out in ISSUE, track
    // read returns through a latency pipe and assemble them MSB-first.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant_q <= PW'(NUM_PORTS - 1);
            we_q         <= 1'b0;
            size_q       <= '0;
            port_q       <= '0;
            wdata_q      <= '0;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
            rd_pipe_q    <= '0;
            asm_q        <= '0;
            rsp_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
        end else begin
            rd_pipe_q[0] <= (state_q == S_ISSUE) && !we_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end

            if (accept) begin
                we_q         <= sel_we;
                size_q       <= sel_size_cl;
                port_q       <= gnt_idx;
                last_grant_q <= gnt_idx;
                wdata_q      <= sel_aligned << WIDTH;
                issue_cnt_q  <= '0;
                cap_cnt_q    <= '0;
                asm_q        <= '0;
                mem_addr_q   <= sel_addr;
                mem_din_q    <= sel_aligned[DW-1 -: WIDTH];
                mem_we_q     <= sel_we;
            end else if (state_q == S_ISSUE) begin
                if (issue_last) begin
                    mem_we_q <= 1'b0;
                end else begin
                    issue_cnt_q <= issue_cnt_q + 1'b1;
                    mem_addr_q  <= mem_addr_q + 1'b1;
                    mem_din_q   <= wdata_q[DW-1 -: WIDTH];
                    wdata_q     <= wdata_q << WIDTH;
                end
            end

            if (capture) begin
                asm_q     <= asm_next;
                cap_cnt_q <= cap_cnt_q + 1'b1;
            end

            // Response data is loaded on entry to RESP and held until the next.
            if (state_q == S_ISSUE && issue_last && we_q) begin
                rsp_data_q <= '0;
            end else if (state_q == S_WAIT && capture_last) begin
                rsp_data_q <= asm_next;
            end
        end
    end

    assign bus.req_ready_out = gnt_onehot;
    assign bus.rsp_valid_out = rsp_valid;
    assign bus.rsp_data_out  = rsp_data_q;
    assign mem_addr_out      = mem_addr_q;
    assign mem_we_out        = mem_we_q;
    assign mem_din_out       = mem_din_q;
    assign state_dbg_out     = state_q;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: latency-parameterised BRAM model, shadow memory
// and round-robin grant model, directed scenarios then randomized traffic.
module tb_chip8_mem_arbiter;
    localparam int NP = 4;
    localparam int AW = 13;
    localparam int W  = 8;
    localparam int MB = 2;
    localparam int RL = 2;
    localparam int SZ = 1;
    localparam int DW = MB * W;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [AW-1:0] mem_addr_out;
    logic          mem_we_out;
    logic [W-1:0]  mem_din_out;
    logic [W-1:0]  mem_dout_in;
    logic          busy_out;
    logic [1:0]    state_dbg_out;

    chip8_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .WIDTH(W), .MAX_BYTES(MB)) bus ();

    chip8_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .WIDTH(W), .MAX_BYTES(MB), .READ_LATENCY(RL)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bus           (bus),
        .mem_addr_out  (mem_addr_out),
        .mem_we_out    (mem_we_out),
        .mem_din_out   (mem_din_out),
        .mem_dout_in   (mem_dout_in),
        .busy_out      (busy_out),
        .state_dbg_out (state_dbg_out)
    );

    // Clock.
    always #5 clk_in = ~clk_in;

    // BRAM model with RL-cycle read latency and a backdoor write port.
    logic [W-1:0]  bram [0:(1<<AW)-1];
    logic [W-1:0]  rd_pipe [0:RL-1];
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [W-1:0]  bd_data;

    always @(posedge clk_in) begin
        if (bd_en) bram[bd_addr] <= bd_data;
        else if (mem_we_out) bram[mem_addr_out] <= mem_din_out;
        rd_pipe[0] <= bram[mem_addr_out];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout_in = rd_pipe[RL-1];

    // Reference model state.
    logic [W-1:0]  ref_mem [0:(1<<AW)-1];
    logic          pend_v    [NP];
    logic          pend_we   [NP];
    logic [AW-1:0] pend_addr [NP];
    logic [SZ-1:0] pend_size [NP];
    logic [DW-1:0] pend_data [NP];
    logic [AW-1:0] bases     [4];
    logic [DW-1:0] exp_q [$];
    int            model_last;
    int            n_tests;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int p = 0; p < NP; p++) begin
            bus.req_valid_in[p]           = pend_v[p];
            bus.req_we_in[p]              = pend_we[p];
            bus.req_addr_in[p*AW +: AW]   = pend_addr[p];
            bus.req_size_in[p*SZ +: SZ]   = pend_size[p];
            bus.req_data_in[p*DW +: DW]   = pend_data[p];
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] addr,
                           input logic [SZ-1:0] size, input logic [DW-1:0] data);
        pend_v[p]    = 1'b1;
        pend_we[p]   = we;
        pend_addr[p] = addr;
        pend_size[p] = size;
        pend_data[p] = data;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [W-1:0] d);
        ref_mem[a] = d;
        bd_addr    = a;
        bd_data    = d;
        bd_en      = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic random_req(input int p);
        logic [AW-1:0] a;
        a = AW'(bases[$urandom_range(0, 3)] + $urandom_range(0, 15));
        set_req(p, 1'($urandom_range(0, 1)), a, SZ'($urandom_range(0, 1)), DW'($urandom));
    endtask

    // Drive pending requests, expect the round-robin winner, then follow the
    // transaction cycle by cycle against the timing and data rules.
    task automatic serve_one(output int gp, output logic [DW-1:0] got_rsp);
        int            exp_p;
        int            n;
        int            total;
        int            wait_cyc;
        int            idx;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] a;
        gp      = -1;
        got_rsp = '0;
        drive_bus();
        #1;
        wait_cyc = 0;
        while (bus.req_ready_out == '0 && wait_cyc < 10) begin
            @(negedge clk_in);
            #1;
            wait_cyc++;
        end
        check_eq("ready_seen", 32'(|bus.req_ready_out), 32'd1);
        if (bus.req_ready_out == '0) return;

        exp_p = -1;
        for (int i = 1; i <= NP; i++) begin
            idx = (model_last + i) % NP;
            if (exp_p < 0 && pend_v[idx]) exp_p = idx;
        end
        if (exp_p < 0) exp_p = 0;
        check_eq("grant", 32'(bus.req_ready_out), 32'(1 << exp_p));
        for (int p = 0; p < NP; p++) if (bus.req_ready_out[p]) gp = p;
        model_last = exp_p;

        n = ((int'(pend_size[exp_p]) > MB - 1) ? MB - 1 : int'(pend_size[exp_p])) + 1;
        exp_data = '0;
        for (int k = 0; k < n; k++) begin
            a = AW'(pend_addr[exp_p] + k);
            if (pend_we[exp_p]) ref_mem[a] = W'(pend_data[exp_p] >> ((n - 1 - k) * W));
            else exp_data = (exp_data << W) | DW'(ref_mem[a]);
        end
        exp_q.push_back(exp_data);
        total = pend_we[exp_p] ? 1 + n : 1 + n + RL;

        @(posedge clk_in);
        @(negedge clk_in);
        pend_v[exp_p] = 1'b0;
        drive_bus();
        #1;
        for (int c = 1; c <= total; c++) begin
            if (c <= n) begin
                a = AW'(pend_addr[exp_p] + (c - 1));
                check_eq("mem_addr", 32'(mem_addr_out), 32'(a));
                check_eq("mem_we", 32'(mem_we_out), 32'(pend_we[exp_p]));
                if (pend_we[exp_p])
                    check_eq("mem_din", 32'(mem_din_out), 32'(W'(pend_data[exp_p] >> ((n - c) * W))));
            end else begin
                check_eq("mem_we_idle", 32'(mem_we_out), 32'd0);
            end
            check_eq("ready_busy", 32'(bus.req_ready_out), 32'd0);
            if (c == 1) check_eq("busy", 32'(busy_out), 32'd1);
            if (c < total) begin
                check_eq("rsp_early", 32'(bus.rsp_valid_out), 32'd0);
            end else begin
                check_eq("rsp_valid", 32'(bus.rsp_valid_out), 32'(1 << exp_p));
                got_rsp = bus.rsp_data_out;
                check_eq("rsp_data", 32'(bus.rsp_data_out), 32'(exp_q.pop_front()));
            end
            @(negedge clk_in);
            #1;
        end
        check_eq("idle_busy", 32'(busy_out), 32'd0);
        check_eq("rsp_pulse", 32'(bus.rsp_valid_out), 32'd0);
        check_eq("rsp_hold", 32'(bus.rsp_data_out), 32'(exp_data));
    endtask

    // Watchdog: the bench must always terminate.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        int            gp;
        logic [DW-1:0] r;
        n_tests    = 0;
        n_fail     = 0;
        rst_in     = 1'b1;
        bd_en      = 1'b0;
        bd_addr    = '0;
        bd_data    = '0;
        model_last = NP - 1;
        bases[0] = 13'h0000;
        bases[1] = 13'h1FF0;
        bases[2] = 13'h0200;
        bases[3] = 13'h0050;
        for (int p = 0; p < NP; p++) begin
            pend_v[p] = 1'b0; pend_we[p] = 1'b0; pend_addr[p] = '0;
            pend_size[p] = '0; pend_data[p] = '0;
        end
        drive_bus();

        // Fill every address the traffic can touch, then fixed test bytes.
        for (int b = 0; b < 4; b++)
            for (int off = 0; off <= 16; off++)
                poke(AW'(bases[b] + off), W'($urandom));
        poke(13'h0200, 8'hA2);
        poke(13'h0201, 8'h2A);
        poke(13'h0050, 8'hF0);
        bd_en = 1'b0;

        // Reset state, with a request already pending.
        set_req(0, 1'b0, 13'h0200, 1'b1, '0);
        drive_bus();
        #1;
        check_eq("rst_ready", 32'(bus.req_ready_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we_out), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr_out), 32'd0);
        check_eq("rst_mem_din", 32'(mem_din_out), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Word read.
        serve_one(gp, r);
        check_eq("t1_port", 32'(gp), 32'd0);
        check_eq("t1_data", 32'(r), 32'h0000A22A);

        // Word write, then read it back through another port.
        set_req(2, 1'b1, 13'h0300, 1'b1, 16'h1234);
        serve_one(gp, r);
        check_eq("t2_port", 32'(gp), 32'd2);
        check_eq("t2_data", 32'(r), 32'd0);
        set_req(1, 1'b0, 13'h0300, 1'b1, '0);
        serve_one(gp, r);
        check_eq("t2_readback", 32'(r), 32'h00001234);

        // Address wrap on a two-byte write, read back across the wrap.
        set_req(3, 1'b1, 13'h1FFF, 1'b1, 16'hBEEF);
        serve_one(gp, r);
        set_req(0, 1'b0, 13'h1FFF, 1'b1, '0);
        serve_one(gp, r);
        check_eq("t4_wrap", 32'(r), 32'h0000BEEF);

        // Single byte read is zero-extended.
        set_req(1, 1'b0, 13'h0050, 1'b0, '0);
        serve_one(gp, r);
        check_eq("t5_byte", 32'(r), 32'h000000F0);

        // Reset during WAIT of a word read.
        set_req(0, 1'b0, 13'h0200, 1'b1, '0);
        drive_bus();
        #1;
        check_eq("t6_ready", 32'(bus.req_ready_out), 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        pend_v[0] = 1'b0;
        drive_bus();
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        check_eq("t6_in_wait", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        set_req(1, 1'b0, 13'h0201, 1'b0, '0);
        drive_bus();
        #1;
        check_eq("t6_mem_we", 32'(mem_we_out), 32'd0);
        check_eq("t6_mem_addr", 32'(mem_addr_out), 32'd0);
        check_eq("t6_mem_din", 32'(mem_din_out), 32'd0);
        check_eq("t6_busy", 32'(busy_out), 32'd0);
        check_eq("t6_rsp_data", 32'(bus.rsp_data_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("t6_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
            check_eq("t6_ready_rst", 32'(bus.req_ready_out), 32'd0);
            @(negedge clk_in);
            #1;
        end
        rst_in     = 1'b0;
        model_last = NP - 1;
        exp_q.delete();

        // Round-robin with every port requesting; port 0 first after reset.
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(13'h0200 + p), 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            serve_one(gp, r);
            check_eq("rr_order", 32'(gp), 32'(i % NP));
            pend_v[i % NP] = 1'b1;
        end
        for (int p = 0; p < NP; p++) pend_v[p] = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 150; it++) begin
            int any;
            any = 0;
            for (int p = 0; p < NP; p++) begin
                if (!pend_v[p] && $urandom_range(0, 1) == 1) random_req(p);
                if (pend_v[p]) any = 1;
            end
            if (any == 0) random_req($urandom_range(0, NP - 1));
            serve_one(gp, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
